power_toggle_monitor: RTL and testbench

- Switching-activity monitor downstream of a combinational power sub-circuit. Consumes the sub-circuit's single output bit as `probe`, one sample per `sample_valid`.
- Over a window of WINDOW valid samples it counts output toggles and cycles-at-one (signal probability), which feed dynamic power estimation.
- Returns results through a valid/ready handshake to the collection logic.

---
 rtl/power_toggle_monitor.sv | 268 ++++++++++++++++++++++++++
 tb/tb_power_toggle_monitor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/power_toggle_monitor.sv
// -----------------------------------------------------------------------------
// power_toggle_monitor
//
// Purpose:
//    Switching-activity monitor for the single output bit of a combinational
//    power sub-circuit. Over a window of WINDOW valid samples it counts probe
//    transitions and samples-at-one (signal probability). The result is then
//    handed to the collection logic through a valid/ready handshake.
//
// Parameters:
//    WINDOW : valid samples per measurement window (2 .. 2^CNT_W-1)
//    CNT_W  : width of every result counter
//
// Optional feature (macro ACT_INPUT_TOGGLE_EN):
//    Adds in_vec[3:0] (sub-circuit primary inputs, sampled with sample_valid)
//    and res_in_toggles, which accumulates popcount(in_vec ^ prev_vec) in RUN.
//
// Ports:
//    clk            in   rising-edge clock
//    rst_n          in   synchronous active-low reset
//    start          in   arms a window (honoured only in IDLE)
//    clr            in   synchronous abort back to IDLE, discards counts
//    sample_valid   in   probe (and in_vec) valid this cycle
//    probe          in   sub-circuit output sample
//    busy           out  high while arming or running a window
//    res_valid      out  result available
//    res_ready      in   consumer accepts result
//    res_toggles    out  probe transitions in window
//    res_ones       out  samples with probe = 1
//    res_ovf        out  some counter saturated during the window
//    in_vec         in   (optional) sub-circuit primary inputs
//    res_in_toggles out  (optional) input bit transitions in window
// -----------------------------------------------------------------------------
module power_toggle_monitor #(
   parameter int WINDOW = 256,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clr,
   input  logic             sample_valid,
   input  logic             probe,
`ifdef ACT_INPUT_TOGGLE_EN
   input  logic [3:0]       in_vec,
   output logic [CNT_W-1:0] res_in_toggles,
`endif
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_toggles,
   output logic [CNT_W-1:0] res_ones,
   output logic             res_ovf
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARM    = 2'd1,
      ST_RUN    = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LP_WINDOW = CNT_W'(WINDOW);
   localparam logic [CNT_W-1:0] LP_MAX    = {CNT_W{1'b1}};

   // Saturating add: result clamps at all-ones.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [2:0]       inc);
      logic [CNT_W+2:0] sum;
      sum = {3'b000, a} + {{CNT_W{1'b0}}, inc};
      if (sum > {3'b000, LP_MAX}) begin
         sat_add = LP_MAX;
      end else begin
         sat_add = sum[CNT_W-1:0];
      end
   endfunction

   // True when the add would have exceeded the counter range.
   function automatic logic sat_ovf(input logic [CNT_W-1:0] a,
                                    input logic [2:0]       inc);
      logic [CNT_W+2:0] sum;
      sum = {3'b000, a} + {{CNT_W{1'b0}}, inc};
      sat_ovf = (sum > {3'b000, LP_MAX});
   endfunction

   // Number of set bits in a 4-bit vector.
   function automatic logic [2:0] popcnt4(input logic [3:0] v);
      popcnt4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_busy;
   logic             r_valid;
   logic [CNT_W-1:0] r_sample_cnt;
   logic             r_prev_probe;
   logic [CNT_W-1:0] r_toggles;
   logic [CNT_W-1:0] r_ones;
   logic             r_ovf;

   logic             w_take;
   logic             w_last;
   logic             w_clear;
   logic [2:0]       w_tog_inc;
   logic [2:0]       w_one_inc;
   logic             w_ovf_any;

`ifdef ACT_INPUT_TOGGLE_EN
   logic [3:0]       r_prev_vec;
   logic [CNT_W-1:0] r_in_toggles;
   logic [2:0]       w_in_inc;
`endif

   // Sample-path decode: which samples count and what each adds.
   always_comb begin
      w_take    = 1'b0;
      w_last    = 1'b0;
      w_clear   = 1'b0;
      w_tog_inc = 3'd0;
      w_one_inc = {2'b00, probe};
      w_take    = sample_valid && ((r_state == ST_ARM) || (r_state == ST_RUN));
      // sample_cnt never exceeds WINDOW-1 here, so the +1 cannot wrap.
      w_last    = sample_valid && (r_state == ST_RUN) &&
                  ((r_sample_cnt + {{(CNT_W-1){1'b0}}, 1'b1}) == LP_WINDOW);
      w_clear   = clr || ((r_state == ST_IDLE) && start);
      // The first (ARM) sample has no predecessor, so it never toggles.
      if (r_state == ST_RUN) begin
         w_tog_inc = {2'b00, probe ^ r_prev_probe};
      end else begin
         w_tog_inc = 3'd0;
      end
   end

`ifdef ACT_INPUT_TOGGLE_EN
   // Input-vector toggle increment, only counted once a predecessor exists.
   always_comb begin
      w_in_inc = 3'd0;
      if (r_state == ST_RUN) begin
         w_in_inc = popcnt4(in_vec ^ r_prev_vec);
      end else begin
         w_in_inc = 3'd0;
      end
   end
`endif

   // Overflow detect across every counter touched by this sample.
   always_comb begin
      w_ovf_any = 1'b0;
      w_ovf_any = sat_ovf(r_toggles, w_tog_inc) | sat_ovf(r_ones, w_one_inc);
`ifdef ACT_INPUT_TOGGLE_EN
      w_ovf_any = w_ovf_any | sat_ovf(r_in_toggles, w_in_inc);
`endif
   end

   // Next-state logic; clr overrides every transition.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_ARM;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ARM: begin
            if (sample_valid) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_ARM;
            end
         end
         ST_RUN: begin
            if (w_last) begin
               w_state_nxt = ST_REPORT;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_REPORT: begin
            if (res_ready) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_REPORT;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (clr) begin
         w_state_nxt = ST_IDLE;
      end else begin
         w_state_nxt = w_state_nxt;
      end
   end

   // State register plus registered busy/res_valid decoded from next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ST_ARM) || (w_state_nxt == ST_RUN);
         r_valid <= (w_state_nxt == ST_REPORT);
      end
   end

   // Window counters; results hold in IDLE until the next start clears them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sample_cnt <= {CNT_W{1'b0}};
         r_prev_probe <= 1'b0;
         r_toggles    <= {CNT_W{1'b0}};
         r_ones       <= {CNT_W{1'b0}};
         r_ovf        <= 1'b0;
      end else if (w_clear) begin
         r_sample_cnt <= {CNT_W{1'b0}};
         r_prev_probe <= 1'b0;
         r_toggles    <= {CNT_W{1'b0}};
         r_ones       <= {CNT_W{1'b0}};
         r_ovf        <= 1'b0;
      end else if (w_take) begin
         r_prev_probe <= probe;
         r_sample_cnt <= (r_state == ST_ARM) ? {{(CNT_W-1){1'b0}}, 1'b1}
                                             : r_sample_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         r_toggles    <= sat_add(r_toggles, w_tog_inc);
         r_ones       <= sat_add(r_ones, w_one_inc);
         r_ovf        <= r_ovf | w_ovf_any;
      end else begin
         r_sample_cnt <= r_sample_cnt;
         r_prev_probe <= r_prev_probe;
         r_toggles    <= r_toggles;
         r_ones       <= r_ones;
         r_ovf        <= r_ovf;
      end
   end

`ifdef ACT_INPUT_TOGGLE_EN
   // Input-vector toggle counter, same clear/saturation rules as the others.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prev_vec   <= 4'd0;
         r_in_toggles <= {CNT_W{1'b0}};
      end else if (w_clear) begin
         r_prev_vec   <= 4'd0;
         r_in_toggles <= {CNT_W{1'b0}};
      end else if (w_take) begin
         r_prev_vec   <= in_vec;
         r_in_toggles <= sat_add(r_in_toggles, w_in_inc);
      end else begin
         r_prev_vec   <= r_prev_vec;
         r_in_toggles <= r_in_toggles;
      end
   end

   assign res_in_toggles = r_in_toggles;
`endif

   assign busy        = r_busy;
   assign res_valid   = r_valid;
   assign res_toggles = r_toggles;
   assign res_ones    = r_ones;
   assign res_ovf     = r_ovf;

endmodule

// File: tb/tb_power_toggle_monitor.sv
// -----------------------------------------------------------------------------
// tb_power_toggle_monitor
//
// Two instances share one stimulus stream: u0 (WINDOW=8, CNT_W=16) and
// u1 (WINDOW=7, CNT_W=3, counters right at their range limit). A window-level
// model tracks, per instance, the phase (idle / collecting / reporting) and
// unbounded raw counts; expected outputs are the raw counts clamped to the
// counter range. Outputs are compared every cycle on the falling edge, and a
// few directed windows pin literal results.
// -----------------------------------------------------------------------------
module tb_power_toggle_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start;
   logic        clr;
   logic        sample_valid;
   logic        probe;
   logic        res_ready;
   logic [3:0]  in_vec;

   logic        busy0, valid0, ovf0;
   logic [15:0] tog0, one0, itog0;
   logic        busy1, valid1, ovf1;
   logic [2:0]  tog1, one1, itog1;

`ifdef ACT_INPUT_TOGGLE_EN
   localparam bit HAS_IN = 1'b1;
`else
   localparam bit HAS_IN = 1'b0;
   assign itog0 = 16'd0;
   assign itog1 = 3'd0;
`endif

   power_toggle_monitor #(.WINDOW(8), .CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
      .sample_valid(sample_valid), .probe(probe),
`ifdef ACT_INPUT_TOGGLE_EN
      .in_vec(in_vec), .res_in_toggles(itog0),
`endif
      .busy(busy0), .res_valid(valid0), .res_ready(res_ready),
      .res_toggles(tog0), .res_ones(one0), .res_ovf(ovf0)
   );

   power_toggle_monitor #(.WINDOW(7), .CNT_W(3)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
      .sample_valid(sample_valid), .probe(probe),
`ifdef ACT_INPUT_TOGGLE_EN
      .in_vec(in_vec), .res_in_toggles(itog1),
`endif
      .busy(busy1), .res_valid(valid1), .res_ready(res_ready),
      .res_toggles(tog1), .res_ones(one1), .res_ovf(ovf1)
   );

   int n_err = 0;
   int n_chk = 0;

   // model: phase 0 idle, 1 collecting (ARM/RUN), 2 reporting
   int         m_w[2]   = '{8, 7};
   int         m_max[2] = '{65535, 7};
   int         m_phase[2];
   int         m_n[2];
   int         m_tog[2];
   int         m_one[2];
   int         m_itog[2];
   bit         m_last[2];
   logic [3:0] m_lastv[2];
   bit         m_live = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int clampv(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // Window-level reference model, advanced on each rising edge.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n || clr) begin
            m_phase[k] = 0; m_n[k] = 0; m_tog[k] = 0; m_one[k] = 0; m_itog[k] = 0;
         end else if (m_phase[k] == 0) begin
            if (start) begin
               m_phase[k] = 1; m_n[k] = 0; m_tog[k] = 0; m_one[k] = 0; m_itog[k] = 0;
            end
         end else if (m_phase[k] == 1) begin
            if (sample_valid) begin
               if (m_n[k] > 0) begin
                  m_tog[k]  += (probe != m_last[k]) ? 1 : 0;
                  m_itog[k] += $countones(in_vec ^ m_lastv[k]);
               end
               m_one[k]  += probe ? 1 : 0;
               m_last[k]  = probe;
               m_lastv[k] = in_vec;
               m_n[k]++;
               if (m_n[k] == m_w[k]) m_phase[k] = 2;
            end
         end else begin
            if (res_ready) m_phase[k] = 0;
         end
      end
      m_live = 1'b1;
   end

   task automatic cmp_inst(input int k, input logic b, input logic v, input int t,
                           input int o, input logic f, input int it);
      int  mx;
      bit  eovf;
      mx   = m_max[k];
      eovf = (m_tog[k] > mx) || (m_one[k] > mx) || (HAS_IN && (m_itog[k] > mx));
      chk($sformatf("u%0d_busy", k),    b, (m_phase[k] == 1));
      chk($sformatf("u%0d_valid", k),   v, (m_phase[k] == 2));
      chk($sformatf("u%0d_toggles", k), t, clampv(m_tog[k], mx));
      chk($sformatf("u%0d_ones", k),    o, clampv(m_one[k], mx));
      chk($sformatf("u%0d_ovf", k),     f, eovf);
      if (HAS_IN) chk($sformatf("u%0d_in_toggles", k), it, clampv(m_itog[k], mx));
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (m_live) begin
         cmp_inst(0, busy0, valid0, int'(tog0), int'(one0), ovf0, int'(itog0));
         cmp_inst(1, busy1, valid1, int'(tog1), int'(one1), ovf1, int'(itog1));
      end
   end

   // Directed window on u0: clr, start, n samples with gap idle cycles between,
   // hold res_ready low rdy cycles, then accept.
   task automatic run_dir(input string nm, input logic [15:0] bits, input int n,
                          input int gap, input int rdy, input int et, input int eo);
      clr = 1'b1; @(negedge clk);
      clr = 1'b0; start = 1'b1; @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         sample_valid = 1'b1; probe = bits[i]; in_vec = 4'($urandom_range(0, 15));
         @(negedge clk);
         if (i != n - 1) begin
            sample_valid = 1'b0; probe = 1'($urandom_range(0, 1));
            repeat (gap) @(negedge clk);
         end
      end
      sample_valid = 1'b0;
      chk({nm, "_valid"},   valid0, 1);
      chk({nm, "_toggles"}, tog0, et);
      chk({nm, "_ones"},    one0, eo);
      chk({nm, "_ovf"},     ovf0, 0);
      for (int i = 0; i < rdy; i++) begin
         sample_valid = 1'b1; probe = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk({nm, "_hold_valid"},   valid0, 1);
         chk({nm, "_hold_toggles"}, tog0, et);
         chk({nm, "_hold_ones"},    one0, eo);
      end
      sample_valid = 1'b0;
      res_ready = 1'b1; @(negedge clk);
      res_ready = 1'b0;
      chk({nm, "_done_valid"}, valid0, 0);
      chk({nm, "_done_ones"},  one0, eo);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; clr = 1'b0; sample_valid = 1'b0;
      probe = 1'b0; res_ready = 1'b0; in_vec = 4'd0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy0, 0);
      chk("rst_valid", valid0, 0);
      chk("rst_toggles", tog0, 0);
      chk("rst_ones", one0, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // alternating probe, result held 5 cycles before acceptance
      run_dir("alt", 16'h00AA, 8, 0, 5, 7, 4);

      // constant 1 every other cycle; u1 saturates exactly at its range top
      run_dir("ones_gap", 16'h00FF, 8, 1, 0, 0, 8);
      chk("u1_sat_ones", one1, 7);
      chk("u1_sat_ovf", ovf1, 0);

      // abort after 3 samples
      clr = 1'b1; @(negedge clk);
      clr = 1'b0; start = 1'b1; @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample_valid = 1'b1; probe = 1'b1; @(negedge clk);
      end
      sample_valid = 1'b0;
      chk("pre_clr_ones", one0, 3);
      clr = 1'b1; @(negedge clk);
      clr = 1'b0;
      chk("clr_busy", busy0, 0);
      chk("clr_valid", valid0, 0);
      chk("clr_ones", one0, 0);
      run_dir("after_clr", 16'h0033, 8, 0, 1, 3, 4);

      // clr and start together: clr wins
      clr = 1'b1; start = 1'b1; @(negedge clk);
      clr = 1'b0; start = 1'b0;
      chk("clr_start_busy", busy0, 0);

      // reset during RUN, start ignored while reset is low
      start = 1'b1; @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample_valid = 1'b1; probe = 1'b1; @(negedge clk);
      end
      sample_valid = 1'b0;
      rst_n = 1'b0; start = 1'b1; @(negedge clk);
      chk("rstrun_busy", busy0, 0);
      chk("rstrun_ones", one0, 0);
      chk("rstrun_valid", valid0, 0);
      @(negedge clk);
      chk("rstrun_busy2", busy0, 0);
      rst_n = 1'b1; start = 1'b0; @(negedge clk);
      chk("rstrun_idle", busy0, 0);
      start = 1'b1; @(negedge clk);
      start = 1'b0;
      chk("rstrun_restart", busy0, 1);

      // randomized traffic, checked by the model every cycle
      for (int c = 0; c < 6000; c++) begin
         start        = ($urandom_range(0, 7) == 0);
         clr          = ($urandom_range(0, 99) == 0);
         sample_valid = 1'($urandom_range(0, 1));
         probe        = (c % 1000 < 500) ? 1'($urandom_range(0, 1))
                                         : ($urandom_range(0, 7) != 0);
         in_vec       = 4'($urandom_range(0, 15));
         res_ready    = ($urandom_range(0, 3) == 0);
         rst_n        = ($urandom_range(0, 699) != 0);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
